// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the game round sequencer
//
// Purpose: state encodings, player home position, default round timing
//          parameters and a saturating score increment helper.
// Ports:   none (package).

package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [15:0] PLAYER_HOME_X = 16'd315;
  localparam logic [15:0] PLAYER_HOME_Y = 16'd344;

  localparam int DEF_LIVES        = 3;
  localparam int DEF_HIT_FRAMES   = 120;
  localparam int DEF_FLASH_FRAMES = 8;
  localparam int DEF_SCORE_FRAMES = 60;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/game_if.sv
// rtl/game_if.sv - button/collision inputs and round-state outputs of game_ctrl
//
// Purpose: bundles the sequencer's frame/button/collision inputs and its
//          freeze, load pulse, flash, lives, score and debug state outputs.
// Modports:
//   master - the sequencer: inputs frame, btnC, collide; drives the rest.
//   slave  - the surroundings: drive frame, btnC, collide; observe the rest.

interface game_if;

  logic        frame;    // one-cycle pulse per video frame
  logic        btnC;     // start/restart button level, debounced
  logic        collide;  // player overlaps a hazard, valid on frame cycles
  logic        game;     // 1 = player movement frozen
  logic        resetp;   // one-cycle load-to-home pulse
  logic        flash;    // player sprite visible when 1
  logic [1:0]  lives;    // remaining lives
  logic [15:0] score;    // survival score
  logic [1:0]  state;    // FSM state for debug display

  modport master (
    input  frame, btnC, collide,
    output game, resetp, flash, lives, score, state
  );

  modport slave (
    output frame, btnC, collide,
    input  game, resetp, flash, lives, score, state
  );

endinterface

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - 8-bit frame counter with clear and runtime terminal limit
//
// Purpose: counts frame pulses, wraps to 0 after reaching limit, and flags
//          count == limit. Shared by score pacing and the HIT window.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   clr        - clears the count (priority over frame)
//   frame      - increment enable
//   limit      - terminal value (inclusive)
//   count      - current count
//   term       - count == limit

module frame_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       frame,
  input  logic [7:0] limit,
  output logic [7:0] count,
  output logic       term
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= 8'd0;
    end else if (frame) begin
      cnt <= (cnt == limit) ? 8'd0 : cnt + 8'd1;
    end
  end

  assign count = cnt;
  assign term  = (cnt == limit);

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - round sequencer: start, lives, score and post-hit flash
//
// Purpose: IDLE/PLAY/HIT/OVER sequencer owning the movement freeze and the
//          player load pulse; tracks lives, score and the HIT flash window.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - game_if.master: frame, btnC, collide in; game, resetp, flash,
//           lives, score, state out (all registered)

module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES        = DEF_LIVES,
  parameter int HIT_FRAMES   = DEF_HIT_FRAMES,
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES,
  parameter int SCORE_FRAMES = DEF_SCORE_FRAMES
) (
  input  logic   clk,
  input  logic   reset,
  game_if.master bus
);

  localparam logic [7:0] HIT_LIM   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] SCORE_LIM = 8'(SCORE_FRAMES - 1);
  localparam logic [7:0] FLASH_DIV = 8'(FLASH_FRAMES);
  localparam logic [7:0] FLASH_LIM = 8'(FLASH_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t      st;
  logic        btnC_q;
  logic        game_r;
  logic        resetp_r;
  logic        flash_r;
  logic [1:0]  lives_r;
  logic [15:0] score_r;

  logic        start;
  logic        clr;
  logic [7:0]  limit;
  logic [7:0]  ftimer;
  logic        fterm;
  logic        flash_tick;

  // btnC_q resets high so a button held through reset is not an edge.
  assign start = bus.btnC & ~btnC_q;

  // The timer's terminal value depends on what it is pacing right now.
  assign limit      = (st == HIT) ? HIT_LIM : SCORE_LIM;
  assign flash_tick = ((ftimer % FLASH_DIV) == FLASH_LIM);

  // Timer held at 0 outside a round; cleared when entering HIT and when
  // returning from HIT so every PLAY/HIT stretch starts counting from 0.
  always_comb begin
    clr = 1'b0;
    case (st)
      IDLE, OVER: clr = 1'b1;
      PLAY:       clr = bus.frame & bus.collide;
      HIT:        clr = bus.frame & fterm;
      default:    clr = 1'b1;
    endcase
  end

  frame_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .frame (bus.frame),
    .limit (limit),
    .count (ftimer),
    .term  (fterm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      btnC_q   <= 1'b1;
      game_r   <= 1'b1;
      resetp_r <= 1'b0;
      flash_r  <= 1'b1;
      lives_r  <= LIVES_INIT;
      score_r  <= 16'd0;
    end else begin
      btnC_q   <= bus.btnC;
      resetp_r <= 1'b0;
      case (st)
        IDLE, OVER: begin
          game_r  <= 1'b1;
          flash_r <= 1'b1;
          if (start) begin
            st       <= PLAY;
            game_r   <= 1'b0;
            resetp_r <= 1'b1;
            lives_r  <= LIVES_INIT;
            score_r  <= 16'd0;
          end
        end
        PLAY: begin
          if (bus.frame) begin
            // A collision suppresses a coincident score tick.
            if (bus.collide) begin
              st      <= HIT;
              game_r  <= 1'b1;
              lives_r <= lives_r - 2'd1;
            end else if (fterm) begin
              score_r <= sat_inc16(score_r);
            end
          end
        end
        HIT: begin
          if (bus.frame) begin
            if (fterm) begin
              flash_r <= 1'b1;
              if (lives_r == 2'd0) begin
                st <= OVER;
              end else begin
                st       <= PLAY;
                game_r   <= 1'b0;
                resetp_r <= 1'b1;
              end
            end else if (flash_tick) begin
              flash_r <= ~flash_r;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.state  = st;
  assign bus.game   = game_r;
  assign bus.resetp = resetp_r;
  assign bus.flash  = flash_r;
  assign bus.lives  = lives_r;
  assign bus.score  = score_r;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl

module tb_game_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   game_bad;

  game_if bus ();

  game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame pulse followed by one idle cycle.
  task automatic do_frame(input logic col);
    bus.frame   = 1'b1;
    bus.collide = col;
    tick();
    bus.frame   = 1'b0;
    bus.collide = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) do_frame(1'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    game_bad    = 0;
    reset       = 1'b1;
    bus.btnC    = 1'b1;
    bus.frame   = 1'b0;
    bus.collide = 1'b0;
    tick(); tick(); tick();

    chk("rst_state",  32'(bus.state),  32'd0);
    chk("rst_game",   32'(bus.game),   32'd1);
    chk("rst_resetp", 32'(bus.resetp), 32'd0);
    chk("rst_flash",  32'(bus.flash),  32'd1);
    chk("rst_lives",  32'(bus.lives),  32'd3);
    chk("rst_score",  32'(bus.score),  32'd0);

    // Button held through reset release: no start.
    reset = 1'b0;
    tick(); tick(); tick();
    chk("held_no_start", 32'(bus.state), 32'd0);

    // Release then press.
    bus.btnC = 1'b0;
    tick();
    bus.btnC = 1'b1;
    tick();
    chk("start_state",  32'(bus.state),  32'd1);
    chk("start_resetp", 32'(bus.resetp), 32'd1);
    chk("start_game",   32'(bus.game),   32'd0);
    chk("start_lives",  32'(bus.lives),  32'd3);
    chk("start_score",  32'(bus.score),  32'd0);
    bus.btnC = 1'b0;
    tick();
    chk("resetp_width", 32'(bus.resetp), 32'd0);

    // 180 survival frames -> 3 points.
    for (int i = 0; i < 180; i++) begin
      do_frame(1'b0);
      if (bus.game !== 1'b0) game_bad++;
    end
    chk("play_game_low", 32'(game_bad), 32'd0);
    chk("score_180",     32'(bus.score), 32'd3);
    chk("play_flash",    32'(bus.flash), 32'd1);

    // Start pulse in PLAY and collide off a frame cycle: ignored.
    bus.btnC = 1'b1;
    tick();
    bus.btnC = 1'b0;
    tick();
    chk("start_in_play",  32'(bus.state),  32'd1);
    chk("start_in_play_p", 32'(bus.resetp), 32'd0);
    bus.collide = 1'b1;
    tick(); tick();
    bus.collide = 1'b0;
    tick();
    chk("nonframe_col_state", 32'(bus.state), 32'd1);
    chk("nonframe_col_lives", 32'(bus.lives), 32'd3);

    // Bring ftimer to 59 so the collision frame is also a score tick.
    frames(59);
    chk("pre_hit_score", 32'(bus.score), 32'd3);
    do_frame(1'b1);
    chk("hit_state", 32'(bus.state), 32'd2);
    chk("hit_lives", 32'(bus.lives), 32'd2);
    chk("hit_score", 32'(bus.score), 32'd3);
    chk("hit_game",  32'(bus.game),  32'd1);
    chk("hit_flash0", 32'(bus.flash), 32'd1);

    frames(7);
    chk("flash_7", 32'(bus.flash), 32'd1);
    frames(1);
    chk("flash_8", 32'(bus.flash), 32'd0);

    // Start pulse in HIT: ignored.
    bus.btnC = 1'b1;
    tick();
    bus.btnC = 1'b0;
    tick();
    chk("start_in_hit", 32'(bus.state), 32'd2);

    frames(8);
    chk("flash_16", 32'(bus.flash), 32'd1);
    frames(103);
    chk("hit_119", 32'(bus.state), 32'd2);

    // 120th HIT frame: PLAY with load pulse on the next clock.
    bus.frame = 1'b1;
    tick();
    bus.frame = 1'b0;
    chk("reentry_state",  32'(bus.state),  32'd1);
    chk("reentry_resetp", 32'(bus.resetp), 32'd1);
    chk("reentry_flash",  32'(bus.flash),  32'd1);
    chk("reentry_game",   32'(bus.game),   32'd0);
    tick();
    chk("reentry_pulse_w", 32'(bus.resetp), 32'd0);

    // Second and third collisions.
    do_frame(1'b1);
    chk("hit2_lives", 32'(bus.lives), 32'd1);
    frames(120);
    chk("hit2_exit", 32'(bus.state), 32'd1);
    do_frame(1'b1);
    chk("hit3_lives", 32'(bus.lives), 32'd0);
    frames(119);
    chk("hit3_pre_over", 32'(bus.state), 32'd2);
    frames(1);
    chk("over_state", 32'(bus.state), 32'd3);
    chk("over_lives", 32'(bus.lives), 32'd0);
    chk("over_game",  32'(bus.game),  32'd1);
    chk("over_score", 32'(bus.score), 32'd3);
    chk("over_flash", 32'(bus.flash), 32'd1);
    frames(3);
    chk("over_hold", 32'(bus.state), 32'd3);

    // Restart from OVER.
    bus.btnC = 1'b1;
    tick();
    chk("restart_state",  32'(bus.state),  32'd1);
    chk("restart_lives",  32'(bus.lives),  32'd3);
    chk("restart_score",  32'(bus.score),  32'd0);
    chk("restart_resetp", 32'(bus.resetp), 32'd1);
    bus.btnC = 1'b0;
    tick();

    // Reset mid-HIT.
    do_frame(1'b1);
    frames(5);
    chk("pre_reset_hit", 32'(bus.state), 32'd2);
    reset = 1'b1;
    tick();
    chk("midrst_state",  32'(bus.state),  32'd0);
    chk("midrst_game",   32'(bus.game),   32'd1);
    chk("midrst_lives",  32'(bus.lives),  32'd3);
    chk("midrst_score",  32'(bus.score),  32'd0);
    chk("midrst_resetp", 32'(bus.resetp), 32'd0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Round sequencer for the game: owns the `game` freeze signal and the `resetp` load pulse that drive the player position block. Tracks lives, score and the post-collision flash window. Sits between button/collision inputs and the player-state and renderer blocks. Advances only on `frame` ticks, except for the start edge.

## Interface
- `LIVES`, 3: lives at round start; 1..3.
- `HIT_FRAMES`, 120: frames spent in HIT after a collision; 1..255.
- `FLASH_FRAMES`, 8: frames per half-period of the `flash` toggle in HIT; 1..255.
- `SCORE_FRAMES`, 60: frames of survival per score point; 1..255.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `frame` in 1: one-cycle pulse per video frame.
- `btnC` in 1: start/restart button, level, already debounced and synchronized.
- `collide` in 1: player overlaps a hazard, level, valid on `frame` cycles.
- `game` out 1: 1 = player movement frozen.
- `resetp` out 1: one-cycle pulse that loads the player to home (315,344).
- `flash` out 1: player sprite visible when 1.
- `lives` out 2: remaining lives.
- `score` out 16: survival score.
- `state` out 2: current FSM state, for debug display.

## Operation
- States: IDLE=0, PLAY=1, HIT=2, OVER=3. All outputs are registered.
- Start edge: `start = btnC & ~btnC_q`. `btnC_q` resets to 1, so a button held through reset does not start a round.
- IDLE: `game`=1, `flash`=1.
  - On `start`: go to PLAY, pulse `resetp`, set `lives`=LIVES, set `score`=0, clear `ftimer`.
- PLAY: `game`=0, `flash`=1.
  - On `frame` with `collide`=1: go to HIT, `lives` decrements, `ftimer` cleared, no score tick in that frame. Collision wins over a coincident score tick.
  - On `frame` with `collide`=0: `ftimer` increments. At SCORE_FRAMES-1 it wraps to 0 and `score` increments, saturating at 16'hFFFF.
  - `collide` is ignored on non-`frame` cycles.
- HIT: `game`=1. `ftimer` counts frames.
  - `flash` inverts on every frame where `ftimer` mod FLASH_FRAMES == FLASH_FRAMES-1.
  - On the frame where `ftimer` == HIT_FRAMES-1:
    - `lives`==0: go to OVER.
    - otherwise: go to PLAY, pulse `resetp`, set `flash`=1, clear `ftimer`.
  - `collide` is ignored.
- OVER: `game`=1, `flash`=1; `score` and `lives` are held.
  - On `start`: same action as the IDLE start.
- `start` is ignored in PLAY and HIT.
- `lives` never underflows: a collision is only accepted in PLAY, and PLAY is only entered with `lives`≥1.

## Timing
- Reset values: state=IDLE, `game`=1, `resetp`=0, `flash`=1, `lives`=LIVES, `score`=0, `ftimer`=0, `btnC_q`=1.
- `reset` has priority over every other input. Reset mid-round returns to IDLE in one cycle and drops any pending `resetp`.
- Start latency:
  - Edge k samples `btnC`=1 with `btnC_q`=0.
  - During cycle k..k+1: state=PLAY, `resetp`=1, `game`=0.
  - From k+1: `resetp`=0.
- `resetp` is exactly one clock wide. It is coincident with the first PLAY cycle; the player's load has priority over movement.
- Collision latency: the `frame` cycle sampling `collide`=1 yields state=HIT, `game`=1 and the decremented `lives` on the next clock.
- Frame timing in HIT:
  - HIT lasts exactly HIT_FRAMES `frame` pulses.
  - The PLAY re-entry `resetp` occurs on the clock after the HIT_FRAMES-th pulse.
- `ftimer` width is 8 bits, unsigned; the compare is equality, never ≥.

## Structure
- Shared package `game_pkg`:
  - state encodings IDLE/PLAY/HIT/OVER;
  - `PLAYER_HOME_X`=16'd315, `PLAYER_HOME_Y`=16'd344;
  - default LIVES, HIT_FRAMES, FLASH_FRAMES and SCORE_FRAMES.
- One sub-module, `frame_timer`: 8-bit counter with `clr`, increment on `frame`, and a terminal flag against a runtime limit. It is shared between score pacing and the HIT window.
- The FSM, edge detect, `lives` and `score` stay in `game_ctrl`.

## Test plan
- Reset with `btnC` held high, then release and press: no start during the hold. PLAY is entered on the press; `resetp` is high for exactly 1 clk; `lives`=3, `score`=0.
- 180 frames in PLAY with `collide`=0: `score`=3, `game`=0 throughout, `flash`=1.
- `collide`=1 on a `frame` cycle that is also a score tick: HIT entered, `lives` 3→2, `score` unchanged. `flash` toggles every 8 frames. After exactly 120 frames: PLAY, `resetp` pulse, `flash`=1.
- Three collisions: after the third HIT window, state=OVER, `lives`=0, `game`=1, score held. A `start` gives PLAY with `lives`=3, `score`=0.
- `collide`=1 on a non-`frame` cycle, and `start` pulses during PLAY and HIT: no state change.
- `reset` asserted mid-HIT: the next cycle shows IDLE, `game`=1, `lives`=3, `score`=0, `resetp`=0.
